// File: rtl/fft_ctrl_pkg.sv
// Shared definitions for the FFT frame controller: state encoding,
// FFT/guard constants and small state-classification helpers.
package fft_ctrl_pkg;

    localparam int N_FFT      = 64;
    localparam int CP_LEN_DEF = 16;
    localparam int LTS_GI_DEF = 32;

    // Window/skip counter width; large enough for N_FFT, LTS_GI and CP_LEN.
    localparam int WIN_CNT_W  = 7;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_GI    = 3'd1,
        ST_LTS1  = 3'd2,
        ST_LTS2  = 3'd3,
        ST_CP    = 3'd4,
        ST_DATA  = 3'd5,
        ST_DRAIN = 3'd6
    } state_t;

    // True for states whose samples are forwarded to the FFT.
    function automatic logic is_pass_state(input state_t s);
        logic r;
        case (s)
            ST_LTS1, ST_LTS2, ST_DATA: r = 1'b1;
            default:                   r = 1'b0;
        endcase
        return r;
    endfunction

    // True for the two long-training windows.
    function automatic logic is_lts_state(input state_t s);
        logic r;
        case (s)
            ST_LTS1, ST_LTS2: r = 1'b1;
            default:          r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/fft_out_frame_cnt.sv
// Counts FFT output-enable cycles while a packet is in flight and flags the
// cycle on which the count reaches the packet's total output length.
module fft_out_frame_cnt
    import fft_ctrl_pkg::*;
#(
    parameter int CNT_W = 15
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             busy,
    input  logic             do_en,
    input  logic [CNT_W-1:0] target,
    output logic             hit,
    output logic             frame_done
);

    logic [CNT_W-1:0] count_r;
    logic             frame_done_r;
    logic             hit_s;

    // Detect the output sample that brings the count up to the target.
    always_comb begin
        hit_s = 1'b0;
        if (busy && do_en && (count_r == (target - CNT_W'(1)))) begin
            hit_s = 1'b1;
        end else begin
            hit_s = 1'b0;
        end
    end

    // Output-sample counter and registered completion pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_r      <= '0;
            frame_done_r <= 1'b0;
        end else begin
            frame_done_r <= hit_s;
            if (!busy || hit_s) begin
                count_r <= '0;
            end else if (do_en) begin
                count_r <= count_r + CNT_W'(1);
            end
        end
    end

    assign hit        = hit_s;
    assign frame_done = frame_done_r;

endmodule

// File: rtl/fft_frame_ctrl.sv
// FFT input sequencer for one received packet: skips the LTS guard and each
// data-symbol cyclic prefix, forwards 64-sample windows to the FFT, tags the
// two LTS windows and reports packet completion from the FFT output count.
// Optional feature macro: FFT_CTRL_CP_BACKOFF_EN (adds cp_backoff input that
// starts each data window a few samples inside the cyclic prefix).
module fft_frame_ctrl
    import fft_ctrl_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int NSYM_W = 8,
    parameter int CP_LEN = CP_LEN_DEF,
    parameter int LTS_GI = LTS_GI_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [NSYM_W-1:0] n_sym,
`ifdef FFT_CTRL_CP_BACKOFF_EN
    input  logic [3:0]        cp_backoff,
`endif
    input  logic              in_valid,
    input  logic [WIDTH-1:0]  in_re,
    input  logic [WIDTH-1:0]  in_im,
    output logic              fft_di_en,
    output logic [WIDTH-1:0]  fft_di_re,
    output logic [WIDTH-1:0]  fft_di_im,
    output logic              fft_lts_in,
    input  logic              fft_do_en,
    output logic              busy,
    output logic [NSYM_W+1:0] sym_idx,
    output logic              frame_done,
    output logic              start_err
);

    localparam int CNT_W  = WIN_CNT_W;
    localparam int OCNT_W = NSYM_W + 7;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cnt_nxt_s;
    logic [NSYM_W+1:0]  sym_idx_r;
    logic [NSYM_W+1:0]  sym_nxt_s;
    logic [NSYM_W-1:0]  n_sym_r;
    logic [CNT_W-1:0]   cp_skip_r;
    logic [CNT_W-1:0]   cp_skip_s;
    logic               accept_s;
    logic               busy_r;
    logic               start_err_r;
    logic               di_en_r;
    logic [WIDTH-1:0]   di_re_r;
    logic [WIDTH-1:0]   di_im_r;
    logic               lts_r;
    logic [NSYM_W:0]    nwin_s;
    logic [OCNT_W-1:0]  target_s;
    logic               frame_hit_s;
    logic               frame_done_s;

`ifdef FFT_CTRL_CP_BACKOFF_EN
    logic [CNT_W-1:0]   backoff_s;

    // Clamp the requested backoff so at least one CP sample is skipped.
    always_comb begin
        backoff_s = {{(CNT_W-4){1'b0}}, cp_backoff};
        cp_skip_s = CNT_W'(CP_LEN);
        if (backoff_s > CNT_W'(CP_LEN - 1)) begin
            cp_skip_s = CNT_W'(1);
        end else begin
            cp_skip_s = CNT_W'(CP_LEN) - backoff_s;
        end
    end
`else
    assign cp_skip_s = CNT_W'(CP_LEN);
`endif

    // Total FFT output samples for the packet: (2 LTS + n_sym data) * 64.
    assign nwin_s   = {1'b0, n_sym_r} + (NSYM_W+1)'(2);
    assign target_s = {nwin_s, 6'b000000};

    fft_out_frame_cnt #(
        .CNT_W (OCNT_W)
    ) u_out_cnt (
        .clock      (clock),
        .reset      (reset),
        .busy       (busy_r),
        .do_en      (fft_do_en),
        .target     (target_s),
        .hit        (frame_hit_s),
        .frame_done (frame_done_s)
    );

    // Next-state, window-counter and symbol-index logic.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        sym_nxt_s   = sym_idx_r;
        accept_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                cnt_nxt_s = '0;
                sym_nxt_s = '0;
                // A start on the frame_done cycle belongs to the old packet.
                if (start && !frame_done_s) begin
                    accept_s    = 1'b1;
                    state_nxt_s = ST_GI;
                    cnt_nxt_s   = in_valid ? CNT_W'(1) : CNT_W'(0);
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_GI: begin
                if (in_valid && (cnt_r == CNT_W'(LTS_GI - 1))) begin
                    state_nxt_s = ST_LTS1;
                    cnt_nxt_s   = '0;
                end else if (in_valid) begin
                    cnt_nxt_s = cnt_r + CNT_W'(1);
                end else begin
                    cnt_nxt_s = cnt_r;
                end
            end
            ST_LTS1: begin
                if (in_valid && (cnt_r == CNT_W'(N_FFT - 1))) begin
                    state_nxt_s = ST_LTS2;
                    cnt_nxt_s   = '0;
                    sym_nxt_s   = sym_idx_r + (NSYM_W+2)'(1);
                end else if (in_valid) begin
                    cnt_nxt_s = cnt_r + CNT_W'(1);
                end else begin
                    cnt_nxt_s = cnt_r;
                end
            end
            ST_LTS2: begin
                if (in_valid && (cnt_r == CNT_W'(N_FFT - 1))) begin
                    state_nxt_s = (n_sym_r == '0) ? ST_DRAIN : ST_CP;
                    cnt_nxt_s   = '0;
                    sym_nxt_s   = sym_idx_r + (NSYM_W+2)'(1);
                end else if (in_valid) begin
                    cnt_nxt_s = cnt_r + CNT_W'(1);
                end else begin
                    cnt_nxt_s = cnt_r;
                end
            end
            ST_CP: begin
                if (in_valid && (cnt_r == (cp_skip_r - CNT_W'(1)))) begin
                    state_nxt_s = ST_DATA;
                    cnt_nxt_s   = '0;
                end else if (in_valid) begin
                    cnt_nxt_s = cnt_r + CNT_W'(1);
                end else begin
                    cnt_nxt_s = cnt_r;
                end
            end
            ST_DATA: begin
                if (in_valid && (cnt_r == CNT_W'(N_FFT - 1))) begin
                    // Window index n_sym+1 is the last data symbol.
                    if (sym_idx_r == ({2'b00, n_sym_r} + (NSYM_W+2)'(1))) begin
                        state_nxt_s = ST_DRAIN;
                    end else begin
                        state_nxt_s = ST_CP;
                    end
                    cnt_nxt_s = '0;
                    sym_nxt_s = sym_idx_r + (NSYM_W+2)'(1);
                end else if (in_valid) begin
                    cnt_nxt_s = cnt_r + CNT_W'(1);
                end else begin
                    cnt_nxt_s = cnt_r;
                end
            end
            ST_DRAIN: begin
                state_nxt_s = ST_DRAIN;
                cnt_nxt_s   = '0;
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = '0;
                sym_nxt_s   = '0;
            end
        endcase
        // Packet completion wins over any input-side progress.
        if (frame_hit_s) begin
            state_nxt_s = ST_IDLE;
            cnt_nxt_s   = '0;
            sym_nxt_s   = '0;
        end else begin
            state_nxt_s = state_nxt_s;
        end
    end

    // State, window counter and symbol index registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            cnt_r     <= '0;
            sym_idx_r <= '0;
        end else begin
            state_r   <= state_nxt_s;
            cnt_r     <= cnt_nxt_s;
            sym_idx_r <= sym_nxt_s;
        end
    end

    // Per-packet configuration captured on an accepted start.
    always_ff @(posedge clock) begin
        if (reset) begin
            n_sym_r   <= '0;
            cp_skip_r <= '0;
        end else if (accept_s) begin
            n_sym_r   <= n_sym;
            cp_skip_r <= cp_skip_s;
        end
    end

    // Busy flag and sticky start-while-busy error.
    always_ff @(posedge clock) begin
        if (reset) begin
            busy_r      <= 1'b0;
            start_err_r <= 1'b0;
        end else begin
            if (frame_hit_s) begin
                busy_r <= 1'b0;
            end else if (accept_s) begin
                busy_r <= 1'b1;
            end
            if (start && busy_r) begin
                start_err_r <= 1'b1;
            end
        end
    end

    // Registered FFT input; data holds its last value between enables.
    always_ff @(posedge clock) begin
        if (reset) begin
            di_en_r <= 1'b0;
            di_re_r <= '0;
            di_im_r <= '0;
            lts_r   <= 1'b0;
        end else begin
            di_en_r <= in_valid && is_pass_state(state_r);
            lts_r   <= in_valid && is_lts_state(state_r);
            if (in_valid && is_pass_state(state_r)) begin
                di_re_r <= in_re;
                di_im_r <= in_im;
            end
        end
    end

    assign fft_di_en  = di_en_r;
    assign fft_di_re  = di_re_r;
    assign fft_di_im  = di_im_r;
    assign fft_lts_in = lts_r;
    assign busy       = busy_r;
    assign sym_idx    = sym_idx_r;
    assign frame_done = frame_done_s;
    assign start_err  = start_err_r;

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Self-checking bench for fft_frame_ctrl: a sample-index model predicts which
// input samples reach the FFT; predictions are queued as samples are driven
// and popped whenever the DUT raises fft_di_en.
module tb_fft_frame_ctrl;

    localparam int WIDTH  = 16;
    localparam int NSYM_W = 8;

    logic              clock = 1'b0;
    logic              reset;
    logic              start;
    logic [NSYM_W-1:0] n_sym;
    logic [3:0]        cp_backoff;
    logic              in_valid;
    logic [WIDTH-1:0]  in_re;
    logic [WIDTH-1:0]  in_im;
    logic              fft_di_en;
    logic [WIDTH-1:0]  fft_di_re;
    logic [WIDTH-1:0]  fft_di_im;
    logic              fft_lts_in;
    logic              fft_do_en;
    logic              busy;
    logic [NSYM_W+1:0] sym_idx;
    logic              frame_done;
    logic              start_err;

    int          total = 0;
    int          bad   = 0;
    logic [32:0] sb_q[$];

    always #5 clock = ~clock;

    fft_frame_ctrl #(
        .WIDTH  (WIDTH),
        .NSYM_W (NSYM_W),
        .CP_LEN (16),
        .LTS_GI (32)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .n_sym      (n_sym),
`ifdef FFT_CTRL_CP_BACKOFF_EN
        .cp_backoff (cp_backoff),
`endif
        .in_valid   (in_valid),
        .in_re      (in_re),
        .in_im      (in_im),
        .fft_di_en  (fft_di_en),
        .fft_di_re  (fft_di_re),
        .fft_di_im  (fft_di_im),
        .fft_lts_in (fft_lts_in),
        .fft_do_en  (fft_do_en),
        .busy       (busy),
        .sym_idx    (sym_idx),
        .frame_done (frame_done),
        .start_err  (start_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: is input sample k (GI sample 0 = k 0) forwarded to the FFT?
    function automatic bit exp_pass(input int k, input int nsym, input int bo);
        int j;
        int p;
        if (k < 32) return 1'b0;
        if (k < 160) return 1'b1;
        j = k - 160;
        p = 80 - bo;
        if ((j / p) >= nsym) return 1'b0;
        return ((j % p) >= (16 - bo));
    endfunction

    function automatic bit exp_lts(input int k);
        return (k >= 32) && (k < 160);
    endfunction

    // One clock: sample outputs 1 ns after the edge and score any FFT input.
    task automatic tick();
        logic        prev_v;
        logic [32:0] e;
        prev_v = in_valid;
        @(posedge clock);
        #1;
        if (fft_di_en === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_en", 32'(fft_di_en), 32'd0);
            end else begin
                e = sb_q.pop_front();
                chk("di_re", 32'(fft_di_re), 32'(e[31:16]));
                chk("di_im", 32'(fft_di_im), 32'(e[15:0]));
                chk("lts_in", 32'(fft_lts_in), 32'(e[32]));
            end
        end else begin
            chk("lts_without_en", 32'(fft_lts_in), 32'd0);
        end
        if (prev_v == 1'b0) begin
            chk("en_after_gap", 32'(fft_di_en), 32'd0);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_en"},   32'(fft_di_en),  32'd0);
        chk({tag, "_re"},   32'(fft_di_re),  32'd0);
        chk({tag, "_im"},   32'(fft_di_im),  32'd0);
        chk({tag, "_lts"},  32'(fft_lts_in), 32'd0);
        chk({tag, "_busy"}, 32'(busy),       32'd0);
        chk({tag, "_sym"},  32'(sym_idx),    32'd0);
        chk({tag, "_fd"},   32'(frame_done), 32'd0);
        chk({tag, "_err"},  32'(start_err),  32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; fft_do_en = 1'b0;
        tick();
        reset = 1'b0;
        sb_q.delete();
    endtask

    // Drive one packet; optionally restart mid-packet or reset at a sample.
    task automatic run_packet(input int nsym, input bit toggle, input int bo,
                              input int again_at, input int abort_at);
        int period;
        int nsamp;
        int target;
        int k;
        int cyc;
        bit first;
        bit v;
        period = 80 - bo;
        nsamp  = 160 + nsym * period + 8;
        target = (2 + nsym) * 64;
        k = 0; cyc = 0; first = 1'b1;
        n_sym      = NSYM_W'(nsym);
        cp_backoff = 4'(bo);
        while (k < nsamp) begin
            v = toggle ? ((cyc % 2) == 0) : 1'b1;
            start    = first;
            in_valid = v;
            if (v) begin
                in_re = 16'(k);
                in_im = 16'(k) ^ 16'h5a5a;
                if (k == again_at) start = 1'b1;
                if (k == abort_at) reset = 1'b1;
                else if (exp_pass(k, nsym, bo)) sb_q.push_back({exp_lts(k), in_re, in_im});
                k++;
            end else begin
                in_re = 16'($urandom);
                in_im = 16'($urandom);
            end
            tick();
            start = 1'b0;
            cyc++;
            if (reset) begin
                reset = 1'b0;
                in_valid = 1'b0;
                check_zero("abort");
                sb_q.delete();
                return;
            end
            if (first) begin
                chk("busy_on_start", 32'(busy), 32'd1);
                first = 1'b0;
            end
        end
        in_valid = 1'b0;
        tick();
        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        chk("sym_idx_drain", 32'(sym_idx), 32'(2 + nsym));
        chk("busy_drain", 32'(busy), 32'd1);
        chk("start_err", 32'(start_err), (again_at >= 0) ? 32'd1 : 32'd0);
        fft_do_en = 1'b1;
        for (int i = 0; i < target; i++) begin
            tick();
            if (i < target - 1) begin
                chk("fd_early", 32'(frame_done), 32'd0);
            end else begin
                chk("fd_pulse", 32'(frame_done), 32'd1);
                chk("busy_after_fd", 32'(busy), 32'd0);
                chk("sym_idx_idle", 32'(sym_idx), 32'd0);
            end
        end
        fft_do_en = 1'b0;
        start = 1'b1;
        in_valid = 1'b1;
        tick();
        start = 1'b0;
        in_valid = 1'b0;
        chk("fd_single", 32'(frame_done), 32'd0);
        chk("coincident_start_ignored", 32'(busy), 32'd0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; n_sym = '0; cp_backoff = 4'd0;
        in_valid = 1'b0; in_re = '0; in_im = '0; fft_do_en = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        check_zero("reset");

        // Continuous input, two data symbols.
        run_packet(2, 1'b0, 0, -1, -1);

        // Same packet with in_valid toggling.
        do_reset();
        run_packet(2, 1'b1, 0, -1, -1);

        // No data symbols: completion after 128 output samples.
        do_reset();
        run_packet(0, 1'b0, 0, -1, -1);

        // Restart mid-LTS2 raises start_err; reset clears it.
        do_reset();
        run_packet(2, 1'b0, 0, 120, -1);
        do_reset();
        chk("err_cleared", 32'(start_err), 32'd0);

        // Reset at sample 200, then a fresh packet.
        run_packet(2, 1'b0, 0, -1, 200);
        run_packet(1, 1'b0, 0, -1, -1);

`ifdef FFT_CTRL_CP_BACKOFF_EN
        // Data window starts 4 samples early: samples 172-235.
        do_reset();
        run_packet(1, 1'b0, 4, -1, -1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
